min_pc_projector: RTL and testbench
===================================

Name: min_pc_projector

Overview:
Upstream feeder of min_pca_score. Streams one standardized feature per beat and projects the feature vector onto the MIN_PC_NUM minor principal-component eigenvectors, using one parallel multiply-accumulate per PC per beat. Presents the completed min_principal_comps vector with a valid/ready handshake. Its output array connects directly to the min_principal_comps input of min_pca_score. All arithmetic is `real`: this is the simulation model of the IDS pipeline.

Parameters:
MIN_PC_NUM, 5, number of minor principal components (matches min_pca_score).
FEAT_NUM, 41, features per record (one frame = FEAT_NUM beats).
PC_IDX_W, $clog2(MIN_PC_NUM+1), width of the coefficient PC index.
FEAT_IDX_W, $clog2(FEAT_NUM), width of the coefficient feature index.

Ports:
clk  input  1  clock; all state changes on the rising edge.
reset  input  1  synchronous, active-high reset.
feat_valid  input  1  feature beat valid.
feat_ready  output  1  block can accept a beat.
feat_data  input  real  standardized feature value.
feat_last  input  1  marks the final beat of a frame.
coef_we  input  1  coefficient write strobe.
coef_pc  input  PC_IDX_W  PC row select (0..MIN_PC_NUM-1); value MIN_PC_NUM selects the mean row (see Optional Feature).
coef_feat  input  FEAT_IDX_W  feature column select.
coef_data  input  real  coefficient value.
pc_valid  output  1  result vector valid.
pc_ready  input  1  downstream accepts the result.
min_principal_comps  output  real [0:MIN_PC_NUM-1]  projected components.
frame_error  output  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset values: feat_ready=0 for the reset cycle, then 1 in IDLE. pc_valid=0, frame_error=0. All accumulators and outputs are 0.0, feat_idx=0, state IDLE. The coefficient RAM is not cleared.
- States:
  - IDLE/ACCUM: feat_ready=1. A beat is accepted when feat_valid&&feat_ready. On each accepted beat, for every j: acc[j] += feat_data*coef[j][feat_idx], then feat_idx++. The first beat moves IDLE to ACCUM.
  - Accepted beat with feat_last=1 and feat_idx==FEAT_NUM-1: copy the updated acc[] into min_principal_comps, go to HOLD, and assert pc_valid on the next cycle (1-cycle latency from the last beat).
  - Accepted beat with feat_last=1 and feat_idx<FEAT_NUM-1 (early last): pulse frame_error, clear acc[] and feat_idx, go to IDLE. No output is produced.
  - Accepted beat with feat_idx==FEAT_NUM-1 and feat_last=0 (missing last): pulse frame_error, clear acc[], go to DRAIN.
  - DRAIN: feat_ready=1. Beats are accepted and discarded. The beat carrying feat_last returns the block to IDLE.
  - HOLD: feat_ready=0, pc_valid=1, min_principal_comps held stable. On pc_ready, go to IDLE with acc[] and feat_idx cleared, pc_valid low the next cycle. pc_valid never drops without pc_ready.
- Coefficient writes:
  - Accepted in any state. The write lands at the clock edge.
  - A beat in the same cycle uses the old coefficient.
  - Writes with coef_pc>MIN_PC_NUM, or coef_feat>=FEAT_NUM, are ignored. Without MEAN_SUB_EN, coef_pc==MIN_PC_NUM is also ignored.
- Reset asserted mid-frame or in HOLD: aborts the frame, returns to the reset values, no frame_error.
- Values: NaN/Inf propagate unmodified. There is no saturation.

Optional Feature:
Macro: MIN_PC_PROJ_MEAN_SUB_EN.
- Defined: coef_pc==MIN_PC_NUM writes mean[coef_feat]. Each beat accumulates (feat_data-mean[feat_idx])*coef[j][feat_idx]. mean[] resets to 0.0.
- Undefined: no mean storage, raw feat_data is used, and mean-row writes are ignored.

Test Plan:
All scenarios use FEAT_NUM=4 and MIN_PC_NUM=2. Coefficients: pc0=[1,0,0,0], pc1=[0.5,0.5,0.5,0.5].
- Nominal: frame [2,4,6,8] with last on beat 3, pc_ready=1 -> pc_valid exactly 1 cycle after beat 3, components={2.0,10.0}, pc_valid for 1 cycle.
- Backpressure: same frame, pc_ready=0 for 3 cycles -> pc_valid and outputs stable for 4 cycles, feat_ready=0 throughout HOLD. The next frame [1,1,1,1] is then accepted and yields {1.0,2.0}.
- Early last: feat_last on beat 1 -> frame_error single pulse, no pc_valid. The next frame [2,4,6,8] yields {2.0,10.0}.
- Missing last: 6 beats with last on beat 5 -> frame_error pulse after beat 3, beats 4-5 discarded, no pc_valid, back to IDLE.
- Reset mid-frame: reset after beat 2 -> all outputs 0, no error. A fresh frame [2,4,6,8] yields {2.0,10.0}. A coefficient write in the same cycle as beat 0 (pc0[0]=3) -> that frame uses the old value 1; the following frame yields pc0=6.0.
- MEAN_SUB_EN defined: mean=[1,1,1,1], frame [2,4,6,8] -> {1.0,8.0}.

Source files
------------

// File: rtl/min_pc_projector.sv
// -----------------------------------------------------------------------------
// min_pc_projector
//
// Streams one standardized feature per beat and projects the feature vector
// onto MIN_PC_NUM minor principal-component eigenvectors (one multiply-
// accumulate per PC per beat). The finished vector is presented on
// min_principal_comps with a pc_valid/pc_ready handshake and feeds the
// min_principal_comps input of min_pca_score directly. Arithmetic is `real`:
// this is the simulation model of the IDS pipeline.
//
// Optional build macro: MIN_PC_PROJ_MEAN_SUB_EN
//   defined   -> coef_pc == MIN_PC_NUM writes a per-feature mean row, and each
//                beat accumulates (feat_data - mean[idx]) * coef[j][idx].
//   undefined -> no mean storage; mean-row writes are ignored.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   feat_valid/ready    feature beat handshake
//   feat_data/last      feature value, last-beat-of-frame marker
//   coef_we/pc/feat/data coefficient RAM write port (row, column, value)
//   pc_valid/ready      result handshake
//   min_principal_comps projected components (held while pc_valid)
//   frame_error         one-cycle pulse on a framing violation
// -----------------------------------------------------------------------------
module min_pc_projector #(
  parameter int MIN_PC_NUM = 5,
  parameter int FEAT_NUM   = 41,
  parameter int PC_IDX_W   = $clog2(MIN_PC_NUM + 1),
  parameter int FEAT_IDX_W = $clog2(FEAT_NUM)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  feat_valid,
  output logic                  feat_ready,
  input  real                   feat_data,
  input  logic                  feat_last,
  input  logic                  coef_we,
  input  logic [PC_IDX_W-1:0]   coef_pc,
  input  logic [FEAT_IDX_W-1:0] coef_feat,
  input  real                   coef_data,
  output logic                  pc_valid,
  input  logic                  pc_ready,
  output real                   min_principal_comps [0:MIN_PC_NUM-1],
  output logic                  frame_error
);

  // Row select wide enough for the coefficient array only; the extra code
  // point MIN_PC_NUM is the mean row and is filtered out by the range check.
  localparam int PC_SEL_W = (MIN_PC_NUM > 1) ? $clog2(MIN_PC_NUM) : 1;

  // Range checks are done one bit wider so FEAT_NUM / MIN_PC_NUM that are
  // powers of two still compare correctly.
  localparam logic [PC_IDX_W:0]     PC_NUM_X      = (PC_IDX_W + 1)'(MIN_PC_NUM);
  localparam logic [FEAT_IDX_W:0]   FEAT_NUM_X    = (FEAT_IDX_W + 1)'(FEAT_NUM);
  localparam logic [FEAT_IDX_W-1:0] FEAT_LAST_IDX = FEAT_IDX_W'(FEAT_NUM - 1);
  localparam logic [FEAT_IDX_W-1:0] IDX_ONE       = FEAT_IDX_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t                  state_r, state_nxt_s;
  logic [FEAT_IDX_W-1:0]   feat_idx_r;
  real                     acc_r      [0:MIN_PC_NUM-1];
  real                     acc_upd_s  [0:MIN_PC_NUM-1];
  real                     comps_r    [0:MIN_PC_NUM-1];
  real                     coef_r     [0:MIN_PC_NUM-1][0:FEAT_NUM-1];
  real                     x_s;
  logic                    feat_ready_r, pc_valid_r, frame_error_r;
  logic                    beat_s, at_last_idx_s;
  logic                    accum_s, publish_s, clear_s, err_s;
  logic                    feat_ok_s, coef_hit_s;
  logic [PC_SEL_W-1:0]     coef_pc_sel_s;

`ifdef MIN_PC_PROJ_MEAN_SUB_EN
  real                     mean_r [0:FEAT_NUM-1];
  logic                    mean_hit_s;
`endif

  assign feat_ready          = feat_ready_r;
  assign pc_valid            = pc_valid_r;
  assign frame_error         = frame_error_r;
  assign min_principal_comps = comps_r;

  assign beat_s        = feat_valid && feat_ready_r;
  assign at_last_idx_s = (feat_idx_r == FEAT_LAST_IDX);
  assign feat_ok_s     = ({1'b0, coef_feat} < FEAT_NUM_X);
  assign coef_hit_s    = coef_we && ({1'b0, coef_pc} < PC_NUM_X) && feat_ok_s;
  assign coef_pc_sel_s = coef_pc[PC_SEL_W-1:0];
`ifdef MIN_PC_PROJ_MEAN_SUB_EN
  assign mean_hit_s    = coef_we && ({1'b0, coef_pc} == PC_NUM_X) && feat_ok_s;
`endif

  // Per-PC multiply-accumulate candidate for the current beat (old coefficients).
  always_comb begin
    x_s = feat_data;
`ifdef MIN_PC_PROJ_MEAN_SUB_EN
    x_s = feat_data - mean_r[feat_idx_r];
`endif
    for (int j = 0; j < MIN_PC_NUM; j++) begin
      acc_upd_s[j] = acc_r[j] + x_s * coef_r[j][feat_idx_r];
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_nxt_s = state_r;
    accum_s     = 1'b0;
    publish_s   = 1'b0;
    clear_s     = 1'b0;
    err_s       = 1'b0;
    case (state_r)
      ST_IDLE, ST_ACCUM: begin
        if (beat_s) begin
          if (feat_last && at_last_idx_s) begin
            publish_s   = 1'b1;
            state_nxt_s = ST_HOLD;
          end else if (feat_last) begin
            // Frame ended early: drop it and start over.
            err_s       = 1'b1;
            clear_s     = 1'b1;
            state_nxt_s = ST_IDLE;
          end else if (at_last_idx_s) begin
            // Frame overran: discard until the sender's last beat shows up.
            err_s       = 1'b1;
            clear_s     = 1'b1;
            state_nxt_s = ST_DRAIN;
          end else begin
            accum_s     = 1'b1;
            state_nxt_s = ST_ACCUM;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_DRAIN: begin
        if (beat_s && feat_last) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_HOLD: begin
        if (pc_ready) begin
          clear_s     = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: begin
        clear_s     = 1'b1;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Accumulators, feature index, result vector and registered handshake flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < MIN_PC_NUM; j++) begin
        acc_r[j]   <= 0.0;
        comps_r[j] <= 0.0;
      end
      feat_idx_r    <= '0;
      feat_ready_r  <= 1'b0;
      pc_valid_r    <= 1'b0;
      frame_error_r <= 1'b0;
    end else begin
      if (clear_s) begin
        for (int j = 0; j < MIN_PC_NUM; j++) acc_r[j] <= 0.0;
        feat_idx_r <= '0;
      end else if (accum_s) begin
        acc_r      <= acc_upd_s;
        feat_idx_r <= feat_idx_r + IDX_ONE;
      end else if (publish_s) begin
        acc_r   <= acc_upd_s;
        comps_r <= acc_upd_s;
      end
      feat_ready_r  <= (state_nxt_s != ST_HOLD);
      pc_valid_r    <= (state_nxt_s == ST_HOLD);
      frame_error_r <= err_s;
    end
  end

  // Coefficient RAM write port; deliberately untouched by reset.
  always_ff @(posedge clk) begin
    if (coef_hit_s) begin
      coef_r[coef_pc_sel_s][coef_feat] <= coef_data;
    end
  end

`ifdef MIN_PC_PROJ_MEAN_SUB_EN
  // Mean row: cleared by reset, written through the coefficient port.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FEAT_NUM; i++) mean_r[i] <= 0.0;
    end else if (mean_hit_s) begin
      mean_r[coef_feat] <= coef_data;
    end
  end
`endif

endmodule

// File: tb/tb_min_pc_projector.sv
module tb_min_pc_projector;

  localparam int PCN = 2;
  localparam int FN  = 4;
  localparam int PW  = $clog2(PCN + 1);
  localparam int FW  = $clog2(FN);

  logic          clk = 1'b0;
  logic          reset;
  logic          feat_valid;
  logic          feat_ready;
  real           feat_data;
  logic          feat_last;
  logic          coef_we;
  logic [PW-1:0] coef_pc;
  logic [FW-1:0] coef_feat;
  real           coef_data;
  logic          pc_valid;
  logic          pc_ready;
  real           comps [0:PCN-1];
  logic          frame_error;

  int  total = 0;
  int  bad   = 0;
  real exp_q [$];

  min_pc_projector #(.MIN_PC_NUM(PCN), .FEAT_NUM(FN)) dut (
    .clk(clk), .reset(reset),
    .feat_valid(feat_valid), .feat_ready(feat_ready),
    .feat_data(feat_data), .feat_last(feat_last),
    .coef_we(coef_we), .coef_pc(coef_pc), .coef_feat(coef_feat), .coef_data(coef_data),
    .pc_valid(pc_valid), .pc_ready(pc_ready),
    .min_principal_comps(comps), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_real(input string tag, input real obs, input real exp);
    total++;
    assert (obs == exp) else begin
      bad++;
      $error("FAIL %s observed=%f expected=%f", tag, obs, exp);
    end
  endtask

  task automatic wcoef(input int pc, input int ft, input real v);
    coef_we   = 1'b1;
    coef_pc   = PW'(pc);
    coef_feat = FW'(ft);
    coef_data = v;
    tick();
    coef_we   = 1'b0;
  endtask

  // Offer one beat and wait (bounded) for it to be taken.
  task automatic send_beat(input real d, input logic last);
    int n;
    feat_valid = 1'b1;
    feat_data  = d;
    feat_last  = last;
    n = 0;
    while (!feat_ready && n < 20) begin
      tick();
      n++;
    end
    chk_bit("beat_accept", feat_ready, 1'b1);
    tick();
    feat_valid = 1'b0;
    feat_last  = 1'b0;
  endtask

  // Four-beat frame with last on beat 3; expected vector is queued when the
  // last beat is driven and popped once pc_valid appears one cycle later.
  task automatic send_frame4(input string tag, input real a, input real b, input real c,
                             input real d, input real e0, input real e1, input bit wr0);
    real x0, x1;
    if (wr0) begin
      coef_we = 1'b1; coef_pc = PW'(0); coef_feat = FW'(0); coef_data = 3.0;
    end
    send_beat(a, 1'b0);
    coef_we = 1'b0;
    chk_bit({tag, "_pcv_early"}, pc_valid, 1'b0);
    send_beat(b, 1'b0);
    send_beat(c, 1'b0);
    exp_q.push_back(e0);
    exp_q.push_back(e1);
    send_beat(d, 1'b1);
    chk_bit({tag, "_pcv_latency"}, pc_valid, 1'b1);
    chk_bit({tag, "_ferr"}, frame_error, 1'b0);
    x0 = exp_q.pop_front();
    x1 = exp_q.pop_front();
    chk_real({tag, "_pc0"}, comps[0], x0);
    chk_real({tag, "_pc1"}, comps[1], x1);
  endtask

  initial begin
    reset = 1'b1; feat_valid = 1'b0; feat_data = 0.0; feat_last = 1'b0;
    coef_we = 1'b0; coef_pc = '0; coef_feat = '0; coef_data = 0.0; pc_ready = 1'b1;
    tick(); tick();
    chk_bit("rst_ready", feat_ready, 1'b0);
    chk_bit("rst_pcv", pc_valid, 1'b0);
    chk_bit("rst_ferr", frame_error, 1'b0);
    chk_real("rst_pc0", comps[0], 0.0);
    chk_real("rst_pc1", comps[1], 0.0);
    reset = 1'b0;
    tick();
    chk_bit("idle_ready", feat_ready, 1'b1);

    for (int i = 0; i < FN; i++) begin
      wcoef(0, i, (i == 0) ? 1.0 : 0.0);
      wcoef(1, i, 0.5);
    end

    // Nominal
    send_frame4("nom", 2.0, 4.0, 6.0, 8.0, 2.0, 10.0, 1'b0);
    tick();
    chk_bit("nom_pcv_one_cycle", pc_valid, 1'b0);

    // Backpressure
    pc_ready = 1'b0;
    send_frame4("bp", 2.0, 4.0, 6.0, 8.0, 2.0, 10.0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk_bit("bp_hold_pcv", pc_valid, 1'b1);
      chk_bit("bp_hold_ready", feat_ready, 1'b0);
      chk_real("bp_hold_pc0", comps[0], 2.0);
      chk_real("bp_hold_pc1", comps[1], 10.0);
      pc_ready = (k == 3);
      tick();
    end
    chk_bit("bp_release_pcv", pc_valid, 1'b0);
    chk_bit("bp_release_ready", feat_ready, 1'b1);
    send_frame4("bp_next", 1.0, 1.0, 1.0, 1.0, 1.0, 2.0, 1'b0);
    tick();

    // Early last
    send_beat(2.0, 1'b0);
    send_beat(4.0, 1'b1);
    chk_bit("early_ferr", frame_error, 1'b1);
    chk_bit("early_pcv", pc_valid, 1'b0);
    tick();
    chk_bit("early_ferr_pulse", frame_error, 1'b0);
    send_frame4("early_next", 2.0, 4.0, 6.0, 8.0, 2.0, 10.0, 1'b0);
    tick();

    // Missing last: six beats, last on beat 5
    for (int i = 0; i < 6; i++) begin
      send_beat(real'(i + 1), (i == 5));
      chk_bit("miss_ferr", frame_error, (i == 3));
      chk_bit("miss_pcv", pc_valid, 1'b0);
    end
    tick();
    chk_bit("miss_idle_pcv", pc_valid, 1'b0);
    chk_bit("miss_idle_ready", feat_ready, 1'b1);
    send_frame4("drain_next", 2.0, 4.0, 6.0, 8.0, 2.0, 10.0, 1'b0);
    tick();

    // Reset mid-frame
    send_beat(2.0, 1'b0);
    send_beat(4.0, 1'b0);
    send_beat(6.0, 1'b0);
    reset = 1'b1;
    tick();
    chk_bit("mid_rst_ready", feat_ready, 1'b0);
    chk_bit("mid_rst_pcv", pc_valid, 1'b0);
    chk_bit("mid_rst_ferr", frame_error, 1'b0);
    chk_real("mid_rst_pc0", comps[0], 0.0);
    chk_real("mid_rst_pc1", comps[1], 0.0);
    reset = 1'b0;
    tick();
    send_frame4("rst_next", 2.0, 4.0, 6.0, 8.0, 2.0, 10.0, 1'b0);
    tick();

    // Coefficient write alongside beat 0 uses the old value
    send_frame4("wr_same", 2.0, 4.0, 6.0, 8.0, 2.0, 10.0, 1'b1);
    tick();
    send_frame4("wr_after", 2.0, 4.0, 6.0, 8.0, 6.0, 10.0, 1'b0);
    tick();

    // Out-of-range row is ignored; restore pc0[0]; write the mean row
    wcoef(3, 0, 100.0);
    wcoef(0, 0, 1.0);
    for (int i = 0; i < FN; i++) wcoef(PCN, i, 1.0);
`ifdef MIN_PC_PROJ_MEAN_SUB_EN
    send_frame4("mean", 2.0, 4.0, 6.0, 8.0, 1.0, 8.0, 1'b0);
`else
    send_frame4("mean_off", 2.0, 4.0, 6.0, 8.0, 2.0, 10.0, 1'b0);
`endif
    tick();
    chk_bit("final_pcv", pc_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
